ex_mul_sequencer: RTL

Multi-cycle multiply controller for the execute stage. It takes over R-type MUL operations (ALUOp 2'b10, funct 6'b000010) from the single-cycle ALU and runs an iterative shift-add multiply. While the multiply is in flight it raises the EX stall flag so the upstream stages hold. It sits beside the EX ALU, takes operands from the same rs/rt buses, and hands its product to the EX result mux.

---
 rtl/ex_mul_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ex_mul_sequencer.sv
// ex_mul_sequencer: multi-cycle shift-add multiply controller for the EX stage.
// Accepts R-type MUL (ALUOp 2'b10, funct 6'b000010), consumes BITS_PER_CYCLE
// multiplier bits per cycle and raises the EX stall while the multiply runs.
// Optional feature macro: EX_MUL_OVF_EN adds a 2*WIDTH accumulator and the
// mul_ovf output (high half of the unsigned product is non-zero).
// BITS_PER_CYCLE must be 1, 2 or 4 and must divide WIDTH.
module ex_mul_sequencer #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall_flag_ex_out,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
`ifdef EX_MUL_OVF_EN
    ,
    output logic             mul_ovf
`endif
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;
`ifdef EX_MUL_OVF_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_result_valid;
    logic [WIDTH-1:0]   r_result;
`ifdef EX_MUL_OVF_EN
    logic               r_mul_ovf;
`endif

    logic               w_is_mul;
    logic               w_can_accept;
    logic               w_mul_accept;
    logic [ACC_W-1:0]   w_pp [BITS_PER_CYCLE];
    logic [ACC_W-1:0]   w_step;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_last;

    // Decode a MUL issue and qualify it with state, flush and (active-low) reset
    assign w_is_mul     = issue_valid && (alu_op == 2'b10) && (funct == 6'b000010);
    assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_mul_accept = w_is_mul && w_can_accept && !flush && reset;
    assign w_last       = (r_count == CNT_W'(N - 1));

    // One shifted copy of the multiplicand per multiplier bit consumed this cycle
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
        assign w_pp[gi] = r_mplier[gi] ? (r_mcand << gi) : '0;
    end

    // Sum the partial products of this iteration into the running accumulator
    always_comb begin
        w_step = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_step = w_step + w_pp[i];
        end
        w_acc_next = r_acc + w_step;
    end

    // Control FSM and datapath registers; reset beats flush, flush beats issue
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_acc          <= '0;
            r_count        <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
`ifdef EX_MUL_OVF_EN
            r_mul_ovf      <= 1'b0;
`endif
        end else if (flush) begin
            // Kill any in-flight op; the last completed result stays visible
            r_state        <= S_IDLE;
            r_acc          <= '0;
            r_count        <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_mul_accept) begin
                        r_mcand  <= ACC_W'(op_a);
                        r_mplier <= op_b;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_count  <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_result       <= w_acc_next[WIDTH-1:0];
`ifdef EX_MUL_OVF_EN
                        r_mul_ovf      <= |w_acc_next[ACC_W-1:WIDTH];
`endif
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall covers the accept cycle plus every BUSY cycle; DONE lets the pipe advance
    assign stall_flag_ex_out = (r_state == S_BUSY) || w_mul_accept;
    assign busy              = r_busy;
    assign result_valid      = r_result_valid;
    assign result            = r_result;
`ifdef EX_MUL_OVF_EN
    assign mul_ovf           = r_mul_ovf;
`endif

endmodule
